// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU with registered result and c/z/n/v flags
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier for opcode 15.
`timescale 1ns/1ps
module alu_seq #(
   parameter int w = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [w-1:0] a,
   input  logic [w-1:0] b,
   input  logic [3:0]   opc,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [w-1:0] y,
   output logic [w-1:0] y_hi,
   output logic [3:0]   flags,
   output logic         err
);
   localparam int SW = $clog2(w);

   typedef enum logic [1:0] {
      IDLE,
      HOLD
`ifdef ALU_SEQ_MUL_EN
      , EXEC
`endif
   } state_t;

   state_t st, nxt;
   logic load;

   logic [w-1:0]  one_w, add_b, sub_b, r_y;
   logic [w:0]    sum, dif, shl_t, shr_t, sra_t;
   logic [SW-1:0] sh;
   logic          c_r, z_r, n_r, v_r, r_err;

   assign one_w = {{(w-1){1'b0}}, 1'b1};
   assign sh    = b[SW-1:0];
   assign add_b = (opc == 4'd12) ? one_w : b;
   assign sub_b = (opc == 4'd13) ? one_w : b;
   assign sum   = {1'b0, a} + {1'b0, add_b};
   assign dif   = {1'b0, a} - {1'b0, sub_b};
   // Shifts carry one guard bit so the last bit shifted out falls into bit w or bit 0.
   assign shl_t = {1'b0, a} << sh;
   assign shr_t = {a, 1'b0} >> sh;
   assign sra_t = $unsigned($signed({a, 1'b0}) >>> sh);

   always_comb begin
      r_y   = '0;
      c_r   = 1'b0;
      v_r   = 1'b0;
      r_err = 1'b0;
      case (opc)
         4'd0, 4'd12: begin
            r_y = sum[w-1:0];
            c_r = sum[w];
            v_r = (a[w-1] == add_b[w-1]) && (sum[w-1] != a[w-1]);
         end
         4'd1, 4'd13, 4'd14: begin
            r_y = dif[w-1:0];
            c_r = dif[w];
            v_r = (a[w-1] != sub_b[w-1]) && (dif[w-1] != a[w-1]);
         end
         4'd2:  r_y = a & b;
         4'd3:  r_y = a | b;
         4'd4:  r_y = a ^ b;
         4'd5:  r_y = ~a;
         4'd6:  r_y = ~(a & b);
         4'd7:  r_y = ~(a | b);
         4'd8:  r_y = ~(a ^ b);
         4'd9: begin
            r_y = shl_t[w-1:0];
            c_r = shl_t[w];
         end
         4'd10: begin
            r_y = shr_t[w:1];
            c_r = shr_t[0];
         end
         4'd11: begin
            r_y = sra_t[w:1];
            c_r = sra_t[0];
         end
         default: r_err = 1'b1;
      endcase
      z_r = (r_y == '0);
      n_r = r_y[w-1];
      // CMP reports the difference in its flags but passes a through.
      if (opc == 4'd14)
         r_y = a;
      if (r_err) begin
         z_r = 1'b0;
         n_r = 1'b0;
      end
   end

`ifdef ALU_SEQ_MUL_EN
   localparam logic [SW:0] CNT_W = (SW+1)'(w);
   logic          start, done;
   logic [w-1:0]  m_a, m_hi, m_lo;
   logic [SW:0]   m_cnt;
   logic [w:0]    m_sum;

   assign m_sum = m_lo[0] ? ({1'b0, m_hi} + {1'b0, m_a}) : {1'b0, m_hi};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_a   <= '0;
         m_hi  <= '0;
         m_lo  <= '0;
         m_cnt <= '0;
      end else if (start) begin
         m_a   <= a;
         m_hi  <= '0;
         m_lo  <= b;
         m_cnt <= '0;
      end else if (st == EXEC && !done) begin
         m_hi  <= m_sum[w:1];
         m_lo  <= {m_sum[0], m_lo[w-1:1]};
         m_cnt <= m_cnt + {{SW{1'b0}}, 1'b1};
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n)
         st <= IDLE;
      else
         st <= nxt;
   end

   always_comb begin
      nxt      = st;
      in_ready = 1'b0;
      load     = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      start    = 1'b0;
      done     = 1'b0;
`endif
      case (st)
         IDLE: in_ready = 1'b1;
         HOLD: begin
            in_ready = out_ready;
            if (out_ready && !in_valid)
               nxt = IDLE;
         end
`ifdef ALU_SEQ_MUL_EN
         EXEC: if (m_cnt == CNT_W) begin
            done = 1'b1;
            nxt  = HOLD;
         end
`endif
         default: nxt = IDLE;
      endcase
      if (in_valid && in_ready) begin
`ifdef ALU_SEQ_MUL_EN
         if (opc == 4'd15) begin
            start = 1'b1;
            nxt   = EXEC;
         end else
`endif
         begin
            load = 1'b1;
            nxt  = HOLD;
         end
      end
   end

   assign out_valid = (st == HOLD);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y     <= '0;
         y_hi  <= '0;
         flags <= '0;
         err   <= 1'b0;
      end else begin
         if (load) begin
            y     <= r_y;
            y_hi  <= '0;
            flags <= {c_r, z_r, n_r, v_r};
            err   <= r_err;
         end
`ifdef ALU_SEQ_MUL_EN
         if (done) begin
            y     <= m_lo;
            y_hi  <= m_hi;
            flags <= {m_hi != '0, {m_hi, m_lo} == '0, 2'b00};
            err   <= 1'b0;
         end
`endif
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (vector table, random vs model, corner sequences)
`timescale 1ns/1ps
module tb_alu_seq;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, out_valid, out_ready, err;
   logic [W-1:0] a, b, y, y_hi;
   logic [3:0]   opc, flags;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [7:0] y;
      logic [7:0] y_hi;
      logic [3:0] flags;
      logic       err;
   } res_t;

   typedef struct {
      string      name;
      logic [3:0] opc;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] y;
      logic [3:0] fl;
   } vec_t;

   alu_seq #(.w(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .opc(opc), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .y_hi(y_hi), .flags(flags), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   // Reference behaviour from the opcode rules, using plain integer arithmetic.
   function automatic res_t model(input int op, input int ia, input int ib);
      res_t r;
      int sa, sb, bb, d, sd, yy, yh, sh, c, z, n, v, e;
      longint p;
      bb = (op == 12 || op == 13) ? 1 : ib;
      sa = (ia >= 128) ? ia - 256 : ia;
      sb = (bb >= 128) ? bb - 256 : bb;
      sh = ib % W;
      c = 0; v = 0; yh = 0; e = 0; yy = 0;
      d = ia - bb;
      sd = sa - sb;
      case (op)
         0, 12: begin
            yy = (ia + bb) & 255;
            c  = (ia + bb) > 255;
            v  = (sa + sb) > 127 || (sa + sb) < -128;
         end
         1, 13, 14: begin
            yy = d & 255;
            c  = ia < bb;
            v  = sd > 127 || sd < -128;
         end
         2: yy = ia & ib;
         3: yy = ia | ib;
         4: yy = ia ^ ib;
         5: yy = ~ia & 255;
         6: yy = ~(ia & ib) & 255;
         7: yy = ~(ia | ib) & 255;
         8: yy = ~(ia ^ ib) & 255;
         9: begin
            yy = (ia << sh) & 255;
            c  = ((ia << sh) >> 8) & 1;
         end
         10: begin
            yy = ia >> sh;
            c  = (sh == 0) ? 0 : (ia >> (sh - 1)) & 1;
         end
         11: begin
            yy = (sa >>> sh) & 255;
            c  = (sh == 0) ? 0 : (ia >> (sh - 1)) & 1;
         end
         default: e = 1;
      endcase
      z = (yy == 0);
      n = (yy >> 7) & 1;
      if (op == 14) yy = ia;
      if (op == 15) begin
`ifdef ALU_SEQ_MUL_EN
         p  = longint'(ia) * longint'(ib);
         yy = int'(p & 255);
         yh = int'(p >> 8);
         c  = (yh != 0);
         z  = (p == 0);
         e  = 0;
`else
         p  = 0;
         yy = 0;
         c  = 0;
         z  = 0;
`endif
         n = 0;
         v = 0;
      end
      r.y     = yy[7:0];
      r.y_hi  = yh[7:0];
      r.flags = {c[0], z[0], n[0], v[0]};
      r.err   = e[0];
      return r;
   endfunction

   function automatic vec_t mk(input string nm, input logic [3:0] o, input logic [7:0] ia,
                               input logic [7:0] ib, input logic [7:0] ey, input logic [3:0] ef);
      vec_t t;
      t.name = nm; t.opc = o; t.a = ia; t.b = ib; t.y = ey; t.fl = ef;
      return t;
   endfunction

   // Issue one transaction with out_ready high; lat counts cycles from accept to out_valid.
   task automatic run_op(input logic [3:0] op, input logic [7:0] ia, input logic [7:0] ib,
                         output int lat, output res_t r);
      int g;
      opc = op; a = ia; b = ib; in_valid = 1'b1; out_ready = 1'b1;
      g = 0;
      while (!in_ready && g < 50) begin
         @(posedge clk); #1; g++;
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      if (!out_valid) chk("result_timeout", 0, 1);
      r = {y, y_hi, flags, err};
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   vec_t   vt[$];
   res_t   r, e;
   res_t   expq[$];
   int     lat, got, idx, ncyc, seen;
   logic [3:0] rop;
   logic [7:0] ra, rb;
   logic [7:0] bp_a[4];
   logic [7:0] bp_b[4];

   initial begin
      vt.push_back(mk("add_ff_01",  4'd0,  8'hFF, 8'h01, 8'h00, 4'b1100));
      vt.push_back(mk("add_7f_01",  4'd0,  8'h7F, 8'h01, 8'h80, 4'b0011));
      vt.push_back(mk("sub_05_07",  4'd1,  8'h05, 8'h07, 8'hFE, 4'b1010));
      vt.push_back(mk("cmp_80_01",  4'd14, 8'h80, 8'h01, 8'h80, 4'b0001));
      vt.push_back(mk("shl_81_1",   4'd9,  8'h81, 8'h01, 8'h02, 4'b1000));
      vt.push_back(mk("sra_80_3",   4'd11, 8'h80, 8'h03, 8'hF0, 4'b0010));
      vt.push_back(mk("shr_81_0",   4'd10, 8'h81, 8'h00, 8'h81, 4'b0010));
      vt.push_back(mk("shr_81_9",   4'd10, 8'h81, 8'h09, 8'h40, 4'b1000));
      vt.push_back(mk("dec_00",     4'd13, 8'h00, 8'h55, 8'hFF, 4'b1010));
      vt.push_back(mk("dec_80",     4'd13, 8'h80, 8'h00, 8'h7F, 4'b0001));
      vt.push_back(mk("xnor_0f_f0", 4'd8,  8'h0F, 8'hF0, 8'h00, 4'b0100));
      vt.push_back(mk("not_00",     4'd5,  8'h00, 8'h00, 8'hFF, 4'b0010));

      // Reset held with in_valid asserted.
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; opc = 4'd0; a = 8'd3; b = 8'd4;
      repeat (2) begin
         @(posedge clk); #1;
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 1);
         chk("rst_y", y, 0);
         chk("rst_y_hi", y_hi, 0);
         chk("rst_flags", flags, 0);
         chk("rst_err", err, 0);
      end
      rst_n = 1'b1;
      run_op(4'd0, 8'd3, 8'd4, lat, r);
      chk("post_rst_y", r.y, 8'd7);
      chk("post_rst_lat", lat, 1);

      foreach (vt[i]) begin
         run_op(vt[i].opc, vt[i].a, vt[i].b, lat, r);
         chk({vt[i].name, "_y"}, r.y, vt[i].y);
         chk({vt[i].name, "_flags"}, r.flags, vt[i].fl);
         chk({vt[i].name, "_y_hi"}, r.y_hi, 0);
         chk({vt[i].name, "_err"}, r.err, 0);
         chk({vt[i].name, "_lat"}, lat, 1);
      end

      // MUL corner cases.
`ifdef ALU_SEQ_MUL_EN
      run_op(4'd15, 8'hFF, 8'hFF, lat, r);
      chk("mul_ff_y", r.y, 8'h01);
      chk("mul_ff_y_hi", r.y_hi, 8'hFE);
      chk("mul_ff_flags", r.flags, 4'b1000);
      chk("mul_ff_lat", lat, W + 1);
      idle_cycle();
      opc = 4'd15; a = 8'h12; b = 8'h34; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("mul_exec_in_ready", in_ready, 0);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mul_rst_out_valid", out_valid, 0);
      chk("mul_rst_in_ready", in_ready, 1);
      chk("mul_rst_y", y, 0);
      seen = 0;
      repeat (W + 4) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("mul_rst_no_result", seen, 0);
`else
      run_op(4'd15, 8'hFF, 8'hFF, lat, r);
      chk("mul_off_err", r.err, 1);
      chk("mul_off_y", r.y, 0);
      chk("mul_off_y_hi", r.y_hi, 0);
      chk("mul_off_flags", r.flags, 0);
      chk("mul_off_lat", lat, 1);
`endif

      // Reset while a result is held discards it.
      idle_cycle();
      opc = 4'd0; a = 8'h11; b = 8'h22; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_y", y, 8'h33);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("hold_rst_out_valid", out_valid, 0);
      chk("hold_rst_y", y, 0);
      chk("hold_rst_flags", flags, 0);

      // Four back-to-back ADDs, sink stalled for the first 3 cycles.
      idle_cycle();
      bp_a = '{8'd10, 8'hFF, 8'h7F, 8'h80};
      bp_b = '{8'd20, 8'h02, 8'h7F, 8'h80};
      idx = 0; got = 0; ncyc = 0;
      for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
         out_ready = (cyc >= 3);
         in_valid  = (idx < 4);
         opc = 4'd0;
         if (idx < 4) begin
            a = bp_a[idx];
            b = bp_b[idx];
         end
         #2;
         if (out_valid) begin
            if (expq.size() == 0) begin
               chk("bp_unexpected_out", 1, 0);
            end else if (out_ready) begin
               chk("bp_order_y", y, expq[0].y);
               chk("bp_order_flags", flags, expq[0].flags);
               void'(expq.pop_front());
               got++;
            end else begin
               chk("bp_hold_y", y, expq[0].y);
               chk("bp_stall_in_ready", in_ready, 0);
            end
         end
         if (in_valid && in_ready) begin
            expq.push_back(model(0, int'(a), int'(b)));
            idx++;
         end
         ncyc = cyc + 1;
         @(posedge clk); #1;
      end
      chk("bp_count", got, 4);
      chk("bp_leftover", expq.size(), 0);
      chk("bp_cycles", ncyc, 7);

      // Random operations against the model.
      idle_cycle();
      for (int i = 0; i < 300; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         run_op(rop, ra, rb, lat, r);
         e = model(int'(rop), int'(ra), int'(rb));
         chk("rnd_y", r.y, e.y);
         chk("rnd_y_hi", r.y_hi, e.y_hi);
         chk("rnd_flags", r.flags, e.flags);
         chk("rnd_err", r.err, e.err);
`ifdef ALU_SEQ_MUL_EN
         chk("rnd_lat", lat, (rop == 4'd15) ? W + 1 : 1);
`else
         chk("rnd_lat", lat, 1);
`endif
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential, handshaked successor to the combinational `alup` ALU, parametrised in operand width. It registers every result and reports carry, zero, negative and overflow flags. An optional iterative unsigned multiplier is included. A valid/ready handshake on both sides lets it sit between a stimulus source and a result sink in the ALU test environment.

## Interface
- `w`, 8: operand and result width. Must be ≥ 4 and a power of two.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  operand/opcode presented
- `in_ready`  out  1  block accepts a transaction this cycle
- `a`, `b`  in  w  operands, unsigned unless noted
- `opc`  in  4  opcode
- `out_valid`  out  1  result registers hold a valid result
- `out_ready`  in  1  sink accepts the result
- `y`  out  w  result; low half for MUL
- `y_hi`  out  w  MUL high half; 0 for all other ops
- `flags`  out  4  {c, z, n, v}
- `err`  out  1  opcode unsupported in this build

## Operation
- Transfer rules: an input is accepted when `in_valid && in_ready`. An output is consumed when `out_valid && out_ready`.
- FSM has three states:
  - IDLE: `in_ready=1`. On accept of a non-MUL op, compute and register the result, then go to HOLD. On accept of MUL, load the multiplier and go to EXEC.
  - EXEC: `in_ready=0`. Runs one shift-add step per cycle. After exactly w steps, register the product and go to HOLD.
  - HOLD: `out_valid=1`. `in_ready=out_ready`. On consume with a simultaneous accept, load the new transaction: a non-MUL op stays in HOLD with the new result; MUL goes to EXEC. On consume with no accept, go to IDLE.
- Opcodes:
  - 0 ADD, 1 SUB (a−b), 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 NAND, 7 NOR, 8 XNOR
  - 9 SHL, 10 SHR (logical), 11 SRA: shift a by b[log2(w)−1:0]
  - 12 INC a, 13 DEC a
  - 14 CMP: y=a, flags taken from a−b
  - 15 MUL
- Flags:
  - c: carry-out for ADD/INC. Borrow (unsigned a<b, or a==0 for DEC) for SUB/DEC/CMP. Last bit shifted out for shifts; 0 when the shift amount is 0. For MUL, c = (`y_hi`≠0). 0 for all logic ops.
  - z: result==0. For CMP, taken from a−b. For MUL, set when the full 2w product is 0.
  - n: `y[w-1]`. For CMP, the MSB of a−b. 0 for MUL.
  - v: two's-complement overflow for ADD/SUB/INC/DEC/CMP, else 0.
- All arithmetic is modulo 2^w, except MUL, which produces the full 2w product.
- `err` is registered with the result and is 0 unless Configuration says otherwise.
- Outputs change only on a state transition into HOLD. They hold stable while `out_valid && !out_ready`.

## Timing
- Reset values: `y=0`, `y_hi=0`, `flags=0`, `err=0`, `out_valid=0`, `in_ready=1`, state IDLE.
- Reset asserted mid-EXEC or mid-HOLD discards the transaction. The next cycle is IDLE with the reset values.
- Non-MUL op accepted at edge N: `out_valid` is high after edge N (latency 1).
- MUL accepted at edge N: `out_valid` is high after edge N+w+1.
- Throughput is one non-MUL op per cycle when `out_ready` stays high. There are no bubbles and no combinational path from `in_valid` to `out_valid`.
- `in_ready` depends combinationally on `out_ready` in HOLD only.

## Configuration
- `ALU_SEQ_MUL_EN` defined: the iterative multiplier is compiled in and opcode 15 behaves as above.
- Undefined: there is no EXEC state and no multiplier datapath. Opcode 15 completes in 1 cycle with `y=0`, `y_hi=0`, `flags=0`, `err=1`.

## Test plan
- Reset: hold `rst_n=0` for 2 cycles with `in_valid=1` -> `out_valid=0`, `in_ready=1`, `y=0`, `flags=0`. The first cycle after release accepts normally.
- ADD, w=8: a=8'hFF, b=8'h01 -> y=8'h00, flags c=1 z=1 n=0 v=0. Then a=8'h7F, b=8'h01 -> y=8'h80, c=0 z=0 n=1 v=1.
- SUB and CMP: SUB a=8'h05, b=8'h07 -> y=8'hFE, c=1 n=1. CMP a=8'h80, b=8'h01 -> y=8'h80, v=1 c=0 z=0.
- Back-to-back with backpressure: issue 4 ADDs with `in_valid` high and `out_ready` low for 3 cycles, then high. Required: the first result is held stable, `in_ready=0` while stalled, and all 4 results emerge in order with no loss or duplication.
- MUL (`ALU_SEQ_MUL_EN` set): a=8'hFF, b=8'hFF -> `y=8'h01`, `y_hi=8'hFE`, c=1, `out_valid` 9 cycles after accept. Reset asserted 3 cycles into EXEC -> IDLE with no result emitted.
- SHL/SRA: SHL a=8'h81, b=1 -> y=8'h02, c=1. SRA a=8'h80, b=3 -> y=8'hF0, c=0. Without the macro, MUL -> `err=1`, latency 1.
